dbus_master_seq: RTL and testbench

DBUS_MASTER_SEQ -- requirements
Module: dbus_master_seq

---
 rtl/dbus_pkg.sv | 22 ++
 rtl/dbus_master_seq_if.sv | 31 +++
 rtl/dbus_wait_timer.sv | 27 ++
 rtl/dbus_master_seq.sv | 109 ++++++++++
 tb/tb_dbus_master_seq.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - shared FSM encoding and wait-state limits for the dbus master
package dbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } dbus_state_t;

  localparam int WAIT_STATES_MIN = 1;
  localparam int WAIT_STATES_MAX = 15;
  localparam int WAIT_CNT_WIDTH  = $clog2(WAIT_STATES_MAX + 1);

  // Out-of-range parameter values are pulled back into the legal window.
  function automatic int clamp_wait(input int w);
    if (w < WAIT_STATES_MIN) return WAIT_STATES_MIN;
    if (w > WAIT_STATES_MAX) return WAIT_STATES_MAX;
    return w;
  endfunction

endpackage

// File: rtl/dbus_master_seq_if.sv
// rtl/dbus_master_seq_if.sv - command and bus signal bundle for dbus_master_seq
interface dbus_master_seq_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
);
  logic                  CmdValid;
  logic                  CmdReady;
  logic                  CmdWr;
  logic [ADDR_WIDTH-1:0] CmdAddr;
  logic [DATA_WIDTH-1:0] CmdData;
  logic [LEN_WIDTH-1:0]  CmdLen;
  logic [ADDR_WIDTH-1:0] Addr;
  logic [DATA_WIDTH-1:0] Dout;
  logic [DATA_WIDTH-1:0] Din;
  logic                  Wr;
  logic                  RspValid;
  logic [DATA_WIDTH-1:0] RspData;
  logic                  RspLast;
  logic                  Busy;

  modport master (
    input  CmdValid, CmdWr, CmdAddr, CmdData, CmdLen, Din,
    output CmdReady, Addr, Dout, Wr, RspValid, RspData, RspLast, Busy
  );

  modport slave (
    output CmdValid, CmdWr, CmdAddr, CmdData, CmdLen, Din,
    input  CmdReady, Addr, Dout, Wr, RspValid, RspData, RspLast, Busy
  );
endinterface

// File: rtl/dbus_wait_timer.sv
// rtl/dbus_wait_timer.sv - setup-phase down-counter, reloaded on every SETUP entry
module dbus_wait_timer
  import dbus_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic load,
  output logic expire
);
  localparam logic [WAIT_CNT_WIDTH-1:0] LOAD_VAL = WAIT_CNT_WIDTH'(clamp_wait(WAIT_STATES));

  logic [WAIT_CNT_WIDTH-1:0] count;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - WAIT_CNT_WIDTH'(1);
    end
  end

  assign expire = (count == '0);
endmodule

// File: rtl/dbus_master_seq.sv
// rtl/dbus_master_seq.sv - wait-stated bus master sequencer with registered outputs
// Bursts (incrementing address, write fill) are built only with DBUS_MASTER_SEQ_BURST_EN.
module dbus_master_seq
  import dbus_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1,
  parameter int LEN_WIDTH   = 4
) (
  input logic               Clk,
  input logic               Rst,
  dbus_master_seq_if.master bus
);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

  dbus_state_t state, next_state;
  logic        accept;
  logic        wr_q;
  logic        expire;
  logic        timer_load;
  logic        last_beat;

  assign accept     = (state == ST_IDLE) && bus.CmdReady && bus.CmdValid;
  assign timer_load = (next_state == ST_SETUP) && (state != ST_SETUP);

  dbus_wait_timer #(.WAIT_STATES(WAIT_STATES)) u_wait_timer (
    .Clk    (Clk),
    .Rst    (Rst),
    .load   (timer_load),
    .expire (expire)
  );

`ifdef DBUS_MASTER_SEQ_BURST_EN
  logic [LEN_WIDTH-1:0] beats_left;

  // Counts down on each re-entry to SETUP, so zero marks the beat in flight as the last.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      beats_left <= '0;
    end else if (accept) begin
      beats_left <= bus.CmdLen;
    end else if (timer_load) begin
      beats_left <= beats_left - LEN_WIDTH'(1);
    end
  end

  assign last_beat = (beats_left == '0);
`else
  logic [LEN_WIDTH-1:0] unused_len;

  assign unused_len = bus.CmdLen;
  assign last_beat  = 1'b1;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (accept) next_state = ST_SETUP;
      ST_SETUP:  if (expire) next_state = ST_ACCESS;
      ST_ACCESS: begin
        if (!wr_q)          next_state = ST_RESP;
        else if (last_beat) next_state = ST_IDLE;
        else                next_state = ST_SETUP;
      end
      ST_RESP:   next_state = last_beat ? ST_IDLE : ST_SETUP;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Every output is a flop keyed off next_state so it lines up with the state it belongs to.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_q         <= 1'b0;
      bus.CmdReady <= 1'b0;
      bus.Busy     <= 1'b0;
      bus.Addr     <= '0;
      bus.Dout     <= DATA_ZERO;
      bus.Wr       <= 1'b0;
      bus.RspValid <= 1'b0;
      bus.RspData  <= DATA_ZERO;
      bus.RspLast  <= 1'b0;
    end else begin
      bus.CmdReady <= (next_state == ST_IDLE);
      bus.Busy     <= (next_state != ST_IDLE);
      bus.Wr       <= (next_state == ST_ACCESS) && wr_q;
      bus.RspValid <= (state == ST_ACCESS) && !wr_q;
      bus.RspLast  <= (state == ST_ACCESS) && !wr_q && last_beat;
      if ((state == ST_ACCESS) && !wr_q) begin
        bus.RspData <= bus.Din;
      end
      if (accept) begin
        wr_q     <= bus.CmdWr;
        bus.Addr <= bus.CmdAddr;
        if (bus.CmdWr) begin
          bus.Dout <= bus.CmdData;
        end
      end else if (timer_load) begin
        bus.Addr <= bus.Addr + ADDR_ONE;
      end
    end
  end
endmodule

// File: tb/tb_dbus_master_seq.sv
// tb/tb_dbus_master_seq.sv - randomized and directed bench for dbus_master_seq against a memory model
module tb_dbus_master_seq;
  localparam int W_A = 1;
  localparam int W_B = 3;
`ifdef DBUS_MASTER_SEQ_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  dbus_master_seq_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(4)) bus_a ();
  dbus_master_seq_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(4)) bus_b ();

  dbus_master_seq #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(W_A), .LEN_WIDTH(4)) u_a (
    .Clk (Clk), .Rst (Rst), .bus (bus_a)
  );
  dbus_master_seq #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(W_B), .LEN_WIDTH(4)) u_b (
    .Clk (Clk), .Rst (Rst), .bus (bus_b)
  );

  logic       sel;
  logic       cmd_valid;
  logic       cmd_wr;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic [3:0] cmd_len;
  logic       mem_init;
  logic [7:0] mem     [2][256];
  logic [7:0] ref_mem [2][256];

  assign bus_a.CmdValid = cmd_valid & ~sel;
  assign bus_b.CmdValid = cmd_valid & sel;
  assign bus_a.CmdWr    = cmd_wr;
  assign bus_b.CmdWr    = cmd_wr;
  assign bus_a.CmdAddr  = cmd_addr;
  assign bus_b.CmdAddr  = cmd_addr;
  assign bus_a.CmdData  = cmd_data;
  assign bus_b.CmdData  = cmd_data;
  assign bus_a.CmdLen   = cmd_len;
  assign bus_b.CmdLen   = cmd_len;
  assign bus_a.Din      = mem[0][bus_a.Addr];
  assign bus_b.Din      = mem[1][bus_b.Addr];

  function automatic logic [7:0] pat(input int s, input int i);
    return 8'((i * 29 + 7) ^ (s * 90));
  endfunction

  // Bus slave memories behind each master.
  always @(posedge Clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem[0][i] <= pat(0, i);
        mem[1][i] <= pat(1, i);
      end
    end else begin
      if (bus_a.Wr) mem[0][bus_a.Addr] <= bus_a.Dout;
      if (bus_b.Wr) mem[1][bus_b.Addr] <= bus_b.Dout;
    end
  end

  logic       o_ready, o_busy, o_wr, o_rv, o_last;
  logic [7:0] o_addr, o_dout, o_rdata;
  assign o_ready = sel ? bus_b.CmdReady : bus_a.CmdReady;
  assign o_busy  = sel ? bus_b.Busy     : bus_a.Busy;
  assign o_wr    = sel ? bus_b.Wr       : bus_a.Wr;
  assign o_rv    = sel ? bus_b.RspValid : bus_a.RspValid;
  assign o_last  = sel ? bus_b.RspLast  : bus_a.RspLast;
  assign o_addr  = sel ? bus_b.Addr     : bus_a.Addr;
  assign o_dout  = sel ? bus_b.Dout     : bus_a.Dout;
  assign o_rdata = sel ? bus_b.RspData  : bus_a.RspData;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One command on master s; expected pulse times and contents come from the timing rules:
  // beat i completes (Wr or RspValid) at i*per + per-1 samples after acceptance,
  // per = W+2 for writes and W+3 for reads, and CmdReady returns at beats*per.
  task automatic run_cmd(input logic s, input logic wr, input logic [7:0] a,
                         input logic [7:0] d, input logic [3:0] len, input bit hold);
    int w, beats, per, k, done_k, n_bad;
    int ev_k[$];
    int ev_a[$];
    int ev_d[$];
    int ev_l[$];
    logic [7:0] ea;
    w     = s ? W_B : W_A;
    beats = BURST ? int'(len) + 1 : 1;
    per   = wr ? w + 2 : w + 3;
    @(negedge Clk);
    sel = s;
    k = 0;
    while (!o_ready && k < 50) begin
      @(negedge Clk);
      k++;
    end
    check("ready_before_cmd", 32'(o_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_len   = len;
    @(posedge Clk);
    @(negedge Clk);
    check("addr_at_accept", 32'(o_addr), 32'(a));
    if (wr) check("dout_at_accept", 32'(o_dout), 32'(d));
    check("busy_ready_after_accept", 32'({o_busy, o_ready}), 32'd2);
    if (hold) begin
      cmd_wr   = ~wr;
      cmd_addr = a ^ 8'h55;
      cmd_data = ~d;
      cmd_len  = 4'd5;
    end else begin
      cmd_valid = 1'b0;
    end
    done_k = -1;
    n_bad  = 0;
    for (k = 0; k < 400; k++) begin
      if (wr ? o_wr : o_rv) begin
        ev_k.push_back(k);
        ev_a.push_back(int'(o_addr));
        ev_d.push_back(int'(wr ? o_dout : o_rdata));
        ev_l.push_back(int'(o_last));
      end
      if (wr ? o_rv : o_wr) n_bad++;
      if (o_ready) begin
        done_k    = k;
        cmd_valid = 1'b0;
        break;
      end
      @(negedge Clk);
    end
    cmd_valid = 1'b0;
    check("done_cycle", 32'(done_k), 32'(beats * per));
    check("pulse_count", 32'(ev_k.size()), 32'(beats));
    check("stray_pulses", 32'(n_bad), 32'd0);
    for (int i = 0; i < beats && i < ev_k.size(); i++) begin
      ea = a + 8'(i);
      check("beat_cycle", 32'(ev_k[i]), 32'(i * per + per - 1));
      check("beat_addr", 32'(ev_a[i]), 32'(ea));
      check("beat_data", 32'(ev_d[i]), 32'(wr ? d : ref_mem[s][ea]));
      check("beat_last", 32'(ev_l[i]), 32'((!wr) && (i == beats - 1)));
    end
    if (wr) begin
      for (int i = 0; i < beats; i++) ref_mem[s][8'(a + 8'(i))] = d;
    end
  endtask

  task automatic reset_abort();
    int k, n_pulse;
    @(negedge Clk);
    sel = 1'b1;
    k = 0;
    while (!o_ready && k < 50) begin
      @(negedge Clk);
      k++;
    end
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = 8'h33;
    cmd_data  = 8'hC3;
    cmd_len   = 4'd0;
    @(posedge Clk);
    @(negedge Clk);
    cmd_valid = 1'b0;
    @(negedge Clk);
    check("abort_in_setup", 32'({o_busy, o_wr}), 32'd2);
    Rst = 1'b1;
    #1;
    check("abort_reset_outputs",
          32'({o_addr, o_dout, o_wr, o_rv, o_rdata, o_last, o_busy, o_ready}), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    n_pulse = 0;
    for (k = 0; k < 10; k++) begin
      @(negedge Clk);
      if (o_wr || o_rv) n_pulse++;
    end
    check("abort_no_pulse", 32'(n_pulse), 32'd0);
    check("abort_ready", 32'({o_busy, o_ready}), 32'd1);
  endtask

  initial begin
    sel       = 1'b0;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = 8'h00;
    cmd_data  = 8'h00;
    cmd_len   = 4'd0;
    mem_init  = 1'b1;
    Rst       = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) ref_mem[s][i] = pat(s, i);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_a", 32'({bus_a.Addr, bus_a.Dout, bus_a.Wr, bus_a.RspValid, bus_a.RspData,
                          bus_a.RspLast, bus_a.Busy, bus_a.CmdReady}), 32'd0);
    check("reset_b", 32'({bus_b.Addr, bus_b.Dout, bus_b.Wr, bus_b.RspValid, bus_b.RspData,
                          bus_b.RspLast, bus_b.Busy, bus_b.CmdReady}), 32'd0);
    mem_init = 1'b0;
    Rst      = 1'b0;
    @(negedge Clk);
    check("ready_after_release", 32'({bus_a.CmdReady, bus_b.CmdReady}), 32'd3);

    run_cmd(1'b0, 1'b1, 8'h10, 8'hA5, 4'd0, 1'b0);
    run_cmd(1'b1, 1'b1, 8'h20, 8'h3C, 4'd0, 1'b0);
    run_cmd(1'b1, 1'b0, 8'h20, 8'h00, 4'd0, 1'b0);
    run_cmd(1'b0, 1'b0, 8'hFE, 8'h00, 4'd2, 1'b0);
    run_cmd(1'b1, 1'b1, 8'h40, 8'h11, 4'd3, 1'b0);
    run_cmd(1'b0, 1'b0, 8'h40, 8'h00, 4'd0, 1'b0);
    reset_abort();
    run_cmd(1'b1, 1'b1, 8'h33, 8'hC3, 4'd0, 1'b0);
    run_cmd(1'b1, 1'b0, 8'h33, 8'h00, 4'd0, 1'b0);
    run_cmd(1'b0, 1'b1, 8'h70, 8'h99, 4'd5, 1'b1);
    run_cmd(1'b0, 1'b0, 8'h70, 8'h00, 4'd5, 1'b1);

    repeat (24) begin
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
              4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
